// File: rtl/mem_access.sv
// Memory-access stage: pass-through for ALU results, multi-cycle data bus access for loads/stores.
// Define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of forcing alignment.
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef REG_BUS
`define REG_BUS 31:0
`endif
`ifndef RST_ENABLE
`define RST_ENABLE 1'b0
`endif
`ifndef WRITE_DISABLE
`define WRITE_DISABLE 1'b0
`endif
`ifndef NOP_REG_ADDR
`define NOP_REG_ADDR 5'b00000
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif

module mem_access (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [`REG_ADDR_BUS] em_des_addr,
  input  logic                 em_des_exist,
  input  logic [`REG_BUS]      em_des_data,
  input  logic [3:0]           em_mem_op,
  input  logic [`REG_BUS]      em_mem_addr,
  input  logic [`REG_BUS]      em_store_data,
  output logic [`REG_ADDR_BUS] mw_des_addr,
  output logic                 mw_des_exist,
  output logic [`REG_BUS]      mw_des_data,
  output logic                 stall_req,
  output logic                 dbus_req,
  output logic                 dbus_we,
  output logic [`REG_BUS]      dbus_addr,
  output logic [3:0]           dbus_sel,
  output logic [`REG_BUS]      dbus_wdata,
  input  logic                 dbus_ack,
  input  logic [`REG_BUS]      dbus_rdata,
  output logic                 mem_align_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_we;
  logic [3:0]    r_sel;
  logic [`REG_BUS] r_addr;
  logic [`REG_BUS] r_wdata;
  logic [`REG_BUS] r_rdata;

  logic w_byte;
  logic w_half;
  logic w_word;
  logic w_load;
  logic w_store;
  logic w_mem;
  logic w_signed;
  logic w_misal;

  logic [3:0]      w_sel;
  logic [`REG_BUS] w_wdata;
  logic [`REG_BUS] w_ldata;
  logic [7:0]      w_lb;
  logic [15:0]     w_lh;

  assign w_byte   = (em_mem_op == OP_LB) | (em_mem_op == OP_LBU)
                  | (em_mem_op == OP_SB);
  assign w_half   = (em_mem_op == OP_LH) | (em_mem_op == OP_LHU)
                  | (em_mem_op == OP_SH);
  assign w_word   = (em_mem_op == OP_LW) | (em_mem_op == OP_SW);
  assign w_store  = (em_mem_op == OP_SB) | (em_mem_op == OP_SH)
                  | (em_mem_op == OP_SW);
  assign w_load   = w_byte | w_half | w_word;
  assign w_mem    = w_load;
  assign w_signed = (em_mem_op == OP_LB) | (em_mem_op == OP_LH);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misal = (w_half & em_mem_addr[0])
                 | (w_word & (|em_mem_addr[1:0]));
`else
  assign w_misal = 1'b0;
`endif

  // big-endian: the lowest address maps to the most significant lane
  always_comb begin
    w_sel = 4'b0000;
    unique case (1'b1)
      w_byte:  w_sel = 4'b1000 >> em_mem_addr[1:0];
      w_half:  w_sel = em_mem_addr[1] ? 4'b0011 : 4'b1100;
      w_word:  w_sel = 4'b1111;
      default: w_sel = 4'b0000;
    endcase
  end

  always_comb begin
    w_wdata = em_store_data;
    unique case (1'b1)
      w_byte:  w_wdata = {4{em_store_data[7:0]}};
      w_half:  w_wdata = {2{em_store_data[15:0]}};
      default: w_wdata = em_store_data;
    endcase
  end

  always_comb begin
    w_lb = r_rdata[31:24];
    unique case (em_mem_addr[1:0])
      2'd0: w_lb = r_rdata[31:24];
      2'd1: w_lb = r_rdata[23:16];
      2'd2: w_lb = r_rdata[15:8];
      2'd3: w_lb = r_rdata[7:0];
      default: w_lb = r_rdata[31:24];
    endcase
    w_lh = em_mem_addr[1] ? r_rdata[15:0] : r_rdata[31:16];
  end

  always_comb begin
    w_ldata = r_rdata;
    unique case (1'b1)
      w_byte:  w_ldata = {{24{w_signed & w_lb[7]}}, w_lb};
      w_half:  w_ldata = {{16{w_signed & w_lh[15]}}, w_lh};
      default: w_ldata = r_rdata;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    stall_req     = 1'b0;
    mem_align_err = 1'b0;
    mw_des_addr   = `NOP_REG_ADDR;
    mw_des_exist  = `WRITE_DISABLE;
    mw_des_data   = `ZERO_WORD;
    unique case (r_state)
      S_IDLE: begin
        if (w_mem && w_misal) begin
          mem_align_err = 1'b1;
        end else if (w_mem) begin
          stall_req = 1'b1;
          w_next    = S_BUSY;
        end else begin
          mw_des_addr  = em_des_addr;
          mw_des_exist = em_des_exist;
          mw_des_data  = em_des_data;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        if (dbus_ack) w_next = S_DONE;
      end
      S_DONE: begin
        mw_des_addr  = em_des_addr;
        mw_des_exist = em_des_exist;
        mw_des_data  = w_store ? em_des_data : w_ldata;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // outputs read as a bubble for as long as reset is held
    if (rst == `RST_ENABLE) begin
      w_next        = S_IDLE;
      stall_req     = 1'b0;
      mem_align_err = 1'b0;
      mw_des_addr   = `NOP_REG_ADDR;
      mw_des_exist  = `WRITE_DISABLE;
      mw_des_data   = `ZERO_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_sel   <= 4'b0000;
      r_addr  <= `ZERO_WORD;
      r_wdata <= `ZERO_WORD;
      r_rdata <= `ZERO_WORD;
    end else begin
      r_state <= w_next;
      // bus fields latch once on BUSY entry and hold for the whole access
      if (r_state == S_IDLE && w_next == S_BUSY) begin
        r_we    <= w_store;
        r_sel   <= w_sel;
        r_addr  <= {em_mem_addr[31:2], 2'b00};
        r_wdata <= w_store ? w_wdata : `ZERO_WORD;
      end
      if (r_state == S_BUSY && dbus_ack) begin
        r_rdata <= dbus_rdata;
      end
    end
  end

  assign dbus_req   = (r_state == S_BUSY);
  assign dbus_we    = r_we;
  assign dbus_sel   = r_sel;
  assign dbus_addr  = r_addr;
  assign dbus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a byte-lane arithmetic model.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic [4:0]  em_des_addr;
  logic        em_des_exist;
  logic [31:0] em_des_data;
  logic [3:0]  em_mem_op;
  logic [31:0] em_mem_addr;
  logic [31:0] em_store_data;
  logic [4:0]  mw_des_addr;
  logic        mw_des_exist;
  logic [31:0] mw_des_data;
  logic        stall_req;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_align_err;

  int n_chk;
  int n_err;

  mem_access dut (
    .clk           (clk),
    .rst           (rst),
    .em_des_addr   (em_des_addr),
    .em_des_exist  (em_des_exist),
    .em_des_data   (em_des_data),
    .em_mem_op     (em_mem_op),
    .em_mem_addr   (em_mem_addr),
    .em_store_data (em_store_data),
    .mw_des_addr   (mw_des_addr),
    .mw_des_exist  (mw_des_exist),
    .mw_des_data   (mw_des_data),
    .stall_req     (stall_req),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_sel      (dbus_sel),
    .dbus_wdata    (dbus_wdata),
    .dbus_ack      (dbus_ack),
    .dbus_rdata    (dbus_rdata),
    .mem_align_err (mem_align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sz(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic int offs(input logic [3:0] op, input logic [31:0] a);
    int s;
    s = sz(op);
    if (s == 4) return 0;
    if (s == 2) return int'(a[1]) * 2;
    return int'(a[1:0]);
  endfunction

  function automatic logic [3:0] exp_sel(input logic [3:0] op,
                                         input logic [31:0] a);
    int s;
    int m;
    s = sz(op);
    m = ((1 << s) - 1) << (4 - offs(op, a) - s);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [3:0] op,
                                         input logic [31:0] d);
    int s;
    s = sz(op);
    if (s == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (s == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    int s;
    int sh;
    logic [31:0] mask;
    logic [31:0] v;
    s    = sz(op);
    sh   = 8 * (4 - offs(op, a) - s);
    mask = (s == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * s)) - 32'h1);
    v    = (rd >> sh) & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8 * s - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic misal(input logic [3:0] op,
                                 input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (sz(op) == 2 && a[0]) || (sz(op) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0 & op[0] & a[0];
`endif
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] da,
                        input logic de, input logic [31:0] dd,
                        input int dly, input logic [31:0] rdata,
                        output logic [31:0] got);
    int  s;
    logic st;
    em_mem_op     = op;
    em_mem_addr   = addr;
    em_store_data = sdata;
    em_des_addr   = da;
    em_des_exist  = de;
    em_des_data   = dd;
    dbus_ack      = 1'b0;
    s  = sz(op);
    st = (op >= 4'd6 && op <= 4'd8);
    got = 32'h0;
    @(negedge clk);
    if (s == 0) begin
      chk("pass_addr", 32'(mw_des_addr), 32'(da));
      chk("pass_exist", 32'(mw_des_exist), 32'(de));
      chk("pass_data", mw_des_data, dd);
      chk("pass_stall", 32'(stall_req), 32'h0);
      chk("pass_req", 32'(dbus_req), 32'h0);
      got = mw_des_data;
      step();
      return;
    end
    if (misal(op, addr)) begin
      chk("mis_err", 32'(mem_align_err), 32'h1);
      chk("mis_stall", 32'(stall_req), 32'h0);
      chk("mis_req", 32'(dbus_req), 32'h0);
      chk("mis_exist", 32'(mw_des_exist), 32'h0);
      step();
      return;
    end
    chk("idle_stall", 32'(stall_req), 32'h1);
    chk("idle_req", 32'(dbus_req), 32'h0);
    chk("idle_exist", 32'(mw_des_exist), 32'h0);
    chk("idle_err", 32'(mem_align_err), 32'h0);
    step();
    for (int k = 0; k < dly; k++) begin
      dbus_rdata = (k == dly - 1) ? rdata : $urandom;
      dbus_ack   = (k == dly - 1);
      @(negedge clk);
      chk("busy_req", 32'(dbus_req), 32'h1);
      chk("busy_we", 32'(dbus_we), 32'(st));
      chk("busy_addr", dbus_addr, {addr[31:2], 2'b00});
      chk("busy_sel", 32'(dbus_sel), 32'(exp_sel(op, addr)));
      if (st) chk("busy_wdata", dbus_wdata, exp_wd(op, sdata));
      chk("busy_stall", 32'(stall_req), 32'h1);
      chk("busy_exist", 32'(mw_des_exist), 32'h0);
      step();
    end
    dbus_ack   = 1'($urandom_range(0, 1));
    dbus_rdata = $urandom;
    @(negedge clk);
    chk("done_req", 32'(dbus_req), 32'h0);
    chk("done_stall", 32'(stall_req), 32'h0);
    chk("done_addr", 32'(mw_des_addr), 32'(da));
    chk("done_exist", 32'(mw_des_exist), 32'(de));
    chk("done_data", mw_des_data, st ? dd : exp_ld(op, addr, rdata));
    got = mw_des_data;
    step();
    dbus_ack = 1'b0;
  endtask

  logic [31:0] got;
  logic [31:0] got2;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    em_des_addr = 5'd7;
    em_des_exist = 1'b1;
    em_des_data = 32'hDEAD_BEEF;
    em_mem_op = 4'd5;
    em_mem_addr = 32'h40;
    em_store_data = 32'h0;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    step();
    step();
    @(negedge clk);
    chk("rst_req", 32'(dbus_req), 32'h0);
    chk("rst_we", 32'(dbus_we), 32'h0);
    chk("rst_sel", 32'(dbus_sel), 32'h0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_wdata", dbus_wdata, 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    chk("rst_exist", 32'(mw_des_exist), 32'h0);
    chk("rst_maddr", 32'(mw_des_addr), 32'h0);
    chk("rst_mdata", mw_des_data, 32'h0);
    chk("rst_err", 32'(mem_align_err), 32'h0);
    step();
    em_mem_op = 4'd0;
    rst = 1'b1;

    run_op(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 1, 32'h0, got);
    chk("add_data", got, 32'h1234);
    run_op(4'd1, 32'h101, 32'h0, 5'd3, 1'b1, 32'h0, 1,
           32'h1180_2233, got);
    chk("lb_data", got, 32'hFFFF_FF80);
    run_op(4'd2, 32'h101, 32'h0, 5'd3, 1'b1, 32'h0, 1,
           32'h1180_2233, got);
    chk("lbu_data", got, 32'h0000_0080);
    run_op(4'd7, 32'h202, 32'hABCD, 5'd0, 1'b0, 32'h55, 4,
           32'h0, got);
    run_op(4'd5, 32'h10, 32'h0, 5'd9, 1'b1, 32'h0, 1,
           32'hCAFE_0001, got);
    run_op(4'd5, 32'h14, 32'h0, 5'd10, 1'b1, 32'h0, 2,
           32'hCAFE_0002, got2);
    chk("lw1_data", got, 32'hCAFE_0001);
    chk("lw2_data", got2, 32'hCAFE_0002);
    run_op(4'd5, 32'h3, 32'h0, 5'd4, 1'b1, 32'h0, 1,
           32'h8765_4321, got);

    em_mem_op = 4'd5;
    em_mem_addr = 32'h40;
    em_des_exist = 1'b1;
    step();
    @(negedge clk);
    chk("pre_rst_req", 32'(dbus_req), 32'h1);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_req", 32'(dbus_req), 32'h0);
    chk("mid_rst_sel", 32'(dbus_sel), 32'h0);
    chk("mid_rst_addr", dbus_addr, 32'h0);
    chk("mid_rst_stall", 32'(stall_req), 32'h0);
    chk("mid_rst_exist", 32'(mw_des_exist), 32'h0);
    step();
    rst = 1'b1;
    em_mem_op = 4'd0;
    em_des_data = 32'h77;
    dbus_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_req", 32'(dbus_req), 32'h0);
    chk("late_ack_data", mw_des_data, 32'h77);
    step();
    dbus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req2", 32'(dbus_req), 32'h0);
    chk("late_ack_stall", 32'(stall_req), 32'h0);
    step();
    run_op(4'd3, 32'h22, 32'h0, 5'd1, 1'b1, 32'h0, 3,
           32'h1234_8001, got);

    for (int i = 0; i < 300; i++) begin
      run_op(4'($urandom_range(0, 11)), $urandom, $urandom,
             5'($urandom), 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(1, 4), $urandom, got);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
